// File: rtl/spm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               state encoding, default operand width and the bit counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_pkg;

  // Default operand width; the product register is twice this wide.
  localparam int DEFAULT_WIDTH = 32;

  // Controller states. The controller keeps its state in a plain 2-bit
  // register and takes its state constants from these enumerators.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } spm_state_e;

  // clog2(width + 1): the bit counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < (width + 1)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : spm_mult_seq_if
// Description : Request / result bundle of the sequential multiplier.
//               The master issues operands and start and selects the product
//               half; the slave (the multiplier) returns product and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface spm_mult_seq_if
  import spm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       mc;
  logic [WIDTH-1:0]       mp;
  logic                   prod_sel;
  logic [WIDTH-1:0]       prod;
  logic [2*WIDTH-1:0]     prod_full;
  logic                   busy;
  logic                   done;
  logic                   ovf;

  modport master (
    output start, signed_mode, mc, mp, prod_sel,
    input  prod, prod_full, busy, done, ovf
  );

  modport slave (
    input  start, signed_mode, mc, mp, prod_sel,
    output prod, prod_full, busy, done, ovf
  );

endinterface
`default_nettype wire

// File: rtl/spm_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : spm_shift_add
// Description : Unsigned shift-add datapath. The multiplier is parked in the
//               low half of the accumulator; each step inspects its LSB,
//               conditionally adds the multiplicand into the high half and
//               shifts the whole accumulator right by one. After WIDTH steps
//               the accumulator holds the full unsigned product.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_shift_add
  import spm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 load,
  input  wire logic                 step,
  input  wire logic [WIDTH-1:0]     mc,
  input  wire logic [WIDTH-1:0]     mp,
  output logic      [2*WIDTH-1:0]   acc
);

  logic [WIDTH-1:0]   r_mc;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     w_sum;

  // Partial sum of the upper half plus the multiplicand when the current
  // multiplier bit is set; one extra bit captures the carry.
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_acc[0]) begin
      w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mc};
    end
  end

  // Load clears the upper half and parks the multiplier below it; step
  // shifts the carry-extended sum in from the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mc  <= '0;
      r_acc <= '0;
    end else if (load) begin
      r_mc  <= mc;
      r_acc <= {{WIDTH{1'b0}}, mp};
    end else if (step) begin
      r_acc <= {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/spm_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : spm_mult_seq
// Description : Parametrised sequential multiplier with signed/unsigned mode.
//               Operands are reduced to magnitudes at start, multiplied by
//               the shift-add datapath over WIDTH cycles, then the sign is
//               applied and overflow judged in a single FIX cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_mult_seq
  import spm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  spm_mult_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_FIX  = ST_FIX;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_signed;
  logic                 r_neg;
  logic                 r_ovf;
  logic [2*WIDTH-1:0]   r_prod;

  logic                 w_accept;
  logic                 w_step;
  logic [WIDTH-1:0]     w_mc_mag;
  logic [WIDTH-1:0]     w_mp_mag;
  logic [2*WIDTH-1:0]   w_acc;
  logic [2*WIDTH-1:0]   w_fixed;
  logic                 w_ovf;

  // Start is honoured only while idle or holding a finished result.
  always_comb begin
    w_accept = 1'b0;
    if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
      w_accept = bus.start;
    end
    w_step = (r_state == S_BUSY);
  end

  // Magnitudes of the operands. Negating the most negative value yields
  // 2^(WIDTH-1), which is still exact when read as an unsigned magnitude.
  always_comb begin
    w_mc_mag = bus.mc;
    w_mp_mag = bus.mp;
    if (bus.signed_mode && bus.mc[WIDTH-1]) begin
      w_mc_mag = -bus.mc;
    end
    if (bus.signed_mode && bus.mp[WIDTH-1]) begin
      w_mp_mag = -bus.mp;
    end
  end

  spm_shift_add #(
    .WIDTH (WIDTH)
  ) u_shift_add (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .step  (w_step),
    .mc    (w_mc_mag),
    .mp    (w_mp_mag),
    .acc   (w_acc)
  );

  // Sign fix-up of the magnitude product and the overflow judgement for the
  // mode latched at start: unsigned needs an empty high half, signed needs
  // the high half plus the low-half MSB to be a pure sign extension.
  always_comb begin
    w_fixed = w_acc;
    if (r_neg) begin
      w_fixed = -w_acc;
    end
    if (r_signed) begin
      w_ovf = !((&w_fixed[2*WIDTH-1:WIDTH-1]) || !(|w_fixed[2*WIDTH-1:WIDTH-1]));
    end else begin
      w_ovf = |w_fixed[2*WIDTH-1:WIDTH];
    end
  end

  // Controller: latches mode and sign at start, counts WIDTH datapath steps,
  // and commits product and overflow in FIX only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_signed <= bus.signed_mode;
            r_neg    <= bus.signed_mode & (bus.mc[WIDTH-1] ^ bus.mp[WIDTH-1]);
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST_BIT) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_prod  <= w_fixed;
          r_ovf   <= w_ovf;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state == S_BUSY) || (r_state == S_FIX);
  assign bus.done      = (r_state == S_DONE);
  assign bus.ovf       = r_ovf;
  assign bus.prod_full = r_prod;
  assign bus.prod      = bus.prod_sel ? r_prod[2*WIDTH-1:WIDTH] : r_prod[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_spm_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_mult_seq
// Description : Self-checking bench for spm_mult_seq at WIDTH=32 and WIDTH=8:
//               directed vector tables, randomized operations against an
//               arithmetic reference, and hand-written reset / restart cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spm_mult_seq_if #(.WIDTH(32)) bus32 ();
  spm_mult_seq_if #(.WIDTH(8))  bus8  ();

  spm_mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  spm_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] mc;
    logic [31:0] mp;
    logic        sm;
    logic [63:0] exp;
    logic        ovf;
  } vec32_t;

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic        sm;
    logic [15:0] exp;
    logic        ovf;
  } vec8_t;

  vec32_t t32[6];
  vec8_t  t8[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication and range tests.
  function automatic void model32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [63:0] p, output logic o);
    longint sa, sb, sp;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      p  = sp;
      o  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    end else begin
      p = {32'd0, a} * {32'd0, b};
      o = (p > 64'h0000_0000_FFFF_FFFF);
    end
  endfunction

  function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 output logic [15:0] p, output logic o);
    int sp;
    if (s) begin
      sp = int'($signed(a)) * int'($signed(b));
      o  = (sp > 127) || (sp < -128);
    end else begin
      sp = int'(a) * int'(b);
      o  = (sp > 255);
    end
    p = 16'(sp);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One 32-bit operation; with noise set, start/operands toggle randomly
  // while the multiplier is busy. lat counts sampling points until done.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input bit noise,
                      output logic [63:0] p, output logic o, output int lat);
    @(negedge clk);
    bus32.mc = a; bus32.mp = b; bus32.signed_mode = s; bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    lat = 1;
    check("busy32_after_start", bus32.busy, 1'b1);
    while (!bus32.done && lat < 200) begin
      if (noise) begin
        bus32.start = 1'($urandom_range(0, 1));
        bus32.mc = $urandom; bus32.mp = $urandom; bus32.signed_mode = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus32.start = 1'b0;
    p = bus32.prod_full;
    o = bus32.ovf;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output logic o, output int lat);
    @(negedge clk);
    bus8.mc = a; bus8.mp = b; bus8.signed_mode = s; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 1;
    check("busy8_after_start", bus8.busy, 1'b1);
    while (!bus8.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    p = bus8.prod_full;
    o = bus8.ovf;
  endtask

  task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input bit noise);
    logic [63:0] p, ep;
    logic        o, eo;
    int          lat;
    model32(a, b, s, ep, eo);
    op32(a, b, s, noise, p, o, lat);
    check({name, "_prod"}, p, ep);
    check({name, "_ovf"}, o, eo);
    check({name, "_latency"}, 64'(lat), 64'd34);
    check({name, "_busy_at_done"}, bus32.busy, 1'b0);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] p, ep;
    logic        o, eo;
    int          lat;
    model8(a, b, s, ep, eo);
    op8(a, b, s, p, o, lat);
    check({name, "_prod"}, p, ep);
    check({name, "_ovf"}, o, eo);
    check({name, "_latency"}, 64'(lat), 64'd10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] p;
    logic        o;
    int          lat;
    int          cnt;
    bit          held;

    t32[0] = '{mc: 32'hFFFF_FFFF, mp: 32'hFFFF_FFFF, sm: 1'b0, exp: 64'hFFFF_FFFE_0000_0001, ovf: 1'b1};
    t32[1] = '{mc: 32'hFFFF_FFFD, mp: 32'h0000_0005, sm: 1'b1, exp: 64'hFFFF_FFFF_FFFF_FFF1, ovf: 1'b0};
    t32[2] = '{mc: 32'hFFFF_FFFD, mp: 32'h0000_0005, sm: 1'b0, exp: 64'h0000_0004_FFFF_FFF1, ovf: 1'b1};
    t32[3] = '{mc: 32'h8000_0000, mp: 32'h8000_0000, sm: 1'b1, exp: 64'h4000_0000_0000_0000, ovf: 1'b1};
    t32[4] = '{mc: 32'h8000_0000, mp: 32'h0000_0001, sm: 1'b1, exp: 64'hFFFF_FFFF_8000_0000, ovf: 1'b0};
    t32[5] = '{mc: 32'h0000_0000, mp: 32'h1234_5678, sm: 1'b1, exp: 64'h0, ovf: 1'b0};

    t8[0] = '{mc: 8'd200, mp: 8'd200, sm: 1'b0, exp: 16'h9C40, ovf: 1'b1};
    t8[1] = '{mc: 8'h80,  mp: 8'h80,  sm: 1'b1, exp: 16'h4000, ovf: 1'b1};
    t8[2] = '{mc: 8'h80,  mp: 8'h01,  sm: 1'b1, exp: 16'hFF80, ovf: 1'b0};
    t8[3] = '{mc: 8'h7F,  mp: 8'h7F,  sm: 1'b1, exp: 16'h3F01, ovf: 1'b1};
    t8[4] = '{mc: 8'd15,  mp: 8'd17,  sm: 1'b0, exp: 16'h00FF, ovf: 1'b0};

    bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.mc = '0; bus32.mp = '0; bus32.prod_sel = 1'b0;
    bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.mc  = '0; bus8.mp  = '0; bus8.prod_sel  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_prod_full32", bus32.prod_full, 64'h0);
    check("rst_busy32", bus32.busy, 1'b0);
    check("rst_done32", bus32.done, 1'b0);
    check("rst_ovf32", bus32.ovf, 1'b0);
    check("rst_prod_full8", bus8.prod_full, 16'h0);
    check("rst_done8", bus8.done, 1'b0);
    rst_n = 1'b1;

    // Directed 32-bit vectors, including both product halves via prod_sel.
    for (int i = 0; i < 6; i++) begin
      op32(t32[i].mc, t32[i].mp, t32[i].sm, 1'b0, p, o, lat);
      check($sformatf("t32_%0d_prod", i), p, t32[i].exp);
      check($sformatf("t32_%0d_ovf", i), o, t32[i].ovf);
      check($sformatf("t32_%0d_latency", i), 64'(lat), 64'd34);
      bus32.prod_sel = 1'b0; #1;
      check($sformatf("t32_%0d_sel_lo", i), bus32.prod, t32[i].exp[31:0]);
      bus32.prod_sel = 1'b1; #1;
      check($sformatf("t32_%0d_sel_hi", i), bus32.prod, t32[i].exp[63:32]);
    end

    // Directed 8-bit vectors.
    for (int i = 0; i < 5; i++) begin
      logic [15:0] p8;
      op8(t8[i].mc, t8[i].mp, t8[i].sm, p8, o, lat);
      check($sformatf("t8_%0d_prod", i), p8, t8[i].exp);
      check($sformatf("t8_%0d_ovf", i), o, t8[i].ovf);
      check($sformatf("t8_%0d_latency", i), 64'(lat), 64'd10);
    end

    // Start pulses and operand churn while busy must not disturb the result.
    run32("noise_a", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b1);
    run32("noise_b", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      run32($sformatf("rnd32_%0d", i), pick32(), pick32(), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 25; i++) begin
      run8($sformatf("rnd8_%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Reset in the middle of BUSY aborts and clears the product register.
    run32("pre_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    bus32.mc = 32'h0001_0000; bus32.mp = 32'h0001_0000; bus32.signed_mode = 1'b0; bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before_reset", bus32.busy, 1'b1);
    rst_n = 1'b0;
    bus32.start = 1'b1;
    @(negedge clk);
    check("mid_reset_busy", bus32.busy, 1'b0);
    check("mid_reset_done", bus32.done, 1'b0);
    check("mid_reset_prod_full", bus32.prod_full, 64'h0);
    check("mid_reset_ovf", bus32.ovf, 1'b0);
    bus32.start = 1'b0;
    rst_n = 1'b1;
    run32("after_reset", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);

    // Back-to-back: start held through DONE restarts immediately.
    run32("b2b_first", 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
    bus32.mc = 32'hFFFF_FFFE; bus32.mp = 32'h0000_0007; bus32.signed_mode = 1'b1; bus32.start = 1'b1;
    cnt  = 0;
    held = 1'b1;
    @(negedge clk);
    while (!bus32.done && cnt < 100) begin
      if (bus32.prod_full !== 64'h0000_0000_0626_0060) held = 1'b0;
      cnt++;
      @(negedge clk);
    end
    bus32.start = 1'b0;
    check("b2b_done_low_cycles", 64'(cnt), 64'd33);
    check("b2b_first_held", held, 1'b1);
    check("b2b_second_prod", bus32.prod_full, 64'hFFFF_FFFF_FFFF_FFF2);
    check("b2b_second_ovf", bus32.ovf, 1'b0);
    @(negedge clk);
    check("b2b_done_holds", bus32.done, 1'b1);
    check("b2b_prod_holds", bus32.prod_full, 64'hFFFF_FFFF_FFFF_FFF2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spm_mult_seq.md
# spm_mult_seq

Parametrised sequential shift-add multiplier: next generation of the 32-bit serial-parallel multiplier in the user project. Adds configurable operand width, per-operation signed/unsigned mode, a full 2·WIDTH product register with half-select, an overflow flag and a defined start/busy/done handshake. It sits inside the user project top, driven from logic-analyser bits and clocked from the wishbone clock.

## Interface
- WIDTH, 32, operand width in bits (≥4); product is 2·WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- mc  in  WIDTH  multiplicand; sampled with start.
- mp  in  WIDTH  multiplier; sampled with start.
- prod_sel  in  1  0 = low half, 1 = high half on prod; combinational select.
- prod  out  WIDTH  selected half of product register.
- prod_full  out  2·WIDTH  full product register.
- busy  out  1  high in BUSY and FIX.
- done  out  1  level, high in DONE.
- ovf  out  1  full product does not fit in WIDTH bits (for current mode); valid while done.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE/DONE, start=1: latch mode; latch |mc|, |mp| (signed mode) or raw values (unsigned); latch neg = signed_mode & (mc[MSB] ^ mp[MSB]); clear accumulator; bit counter = 0; → BUSY. done drops on this edge.
- BUSY: each edge consumes one multiplier bit (LSB first), adds multiplicand to accumulator when bit = 1, shifts; counter increments; after WIDTH edges → FIX.
- FIX: one edge; product register ← neg ? −acc : acc (2·WIDTH-bit two's complement); ovf computed; → DONE.
- DONE: holds product, done=1 until next start or reset.
- start in BUSY/FIX ignored (no queueing); mc/mp/signed_mode changes after the start edge have no effect.
- Absolute value of −2^(WIDTH−1) is 2^(WIDTH−1), representable in the WIDTH-bit unsigned magnitude register; result exact.
- ovf unsigned: prod_full[2W−1:W] ≠ 0. ovf signed: prod_full[2W−1:W−1] not all-equal.
- Product register updates only in FIX; prod/prod_full stable in all other states.

## Timing
- Reset (rst_n=0 at edge): state IDLE, prod_full=0, prod=0, busy=0, done=0, ovf=0, counter=0. Reset in any state, including mid-BUSY, aborts with no product update.
- start accepted at edge E: busy=1 after E; FIX on edge E+WIDTH; done=1, busy=0 after edge E+WIDTH+1. Latency WIDTH+2 edges start-to-done.
- Back-to-back: start held high in DONE restarts at next edge; done low for exactly WIDTH+1 cycles.
- rst_n low and start high same edge: reset wins.
- prod_sel has zero-cycle latency (mux only).

## Structure
- Package spm_pkg: state enum (IDLE, BUSY, FIX, DONE), default WIDTH constant, counter width function clog2(WIDTH+1).
- One sub-module, spm_shift_add: accumulator + shift datapath (load, step, enable); FSM, sign handling and ovf stay in spm_mult_seq.

## Test plan
- WIDTH=32 unsigned: mc=mp=0xFFFFFFFF, start → prod_full=0xFFFFFFFE_00000001, ovf=1; prod_sel=0 → 0x00000001, prod_sel=1 → 0xFFFFFFFE.
- WIDTH=32 signed: mc=−3 (0xFFFFFFFD), mp=5 → prod_full=0xFFFFFFFF_FFFFFFF1, ovf=0; same operands unsigned → 0x00000004_FFFFFFF1, ovf=1.
- Latency: start at edge E → busy from E, done first high after E+33 (WIDTH=32); start pulses during BUSY leave result and timing unchanged.
- WIDTH=8 instance: 200×200 unsigned → 0x9C40, ovf=1; signed −128×−128 → 0x4000, ovf=1; signed −128×1 → 0xFF80, ovf=0.
- Reset mid-op: rst_n low at BUSY cycle 10 → next cycle IDLE, busy=0, done=0, prod_full=0; new start then completes normally.
- Back-to-back: start held high through DONE with new operands → done deasserts, second product correct after WIDTH+2 edges, first product visible until FIX of second.
